// File: rtl/quad_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// quad_pkg: shared FSM/transition types and phase decode for the quadrature
// front end.                                                   Rev 1.0
// ---------------------------------------------------------------------------
package quad_pkg;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    TR_NONE    = 2'd0,
    TR_FWD     = 2'd1,
    TR_REV     = 2'd2,
    TR_ILLEGAL = 2'd3
  } trans_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00 ({A,B}).
  function automatic logic [1:0] fwd_next(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_01;
      PH_01:   nxt = PH_11;
      PH_11:   nxt = PH_10;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
    trans_t t;
    if (prev == cur)                t = TR_NONE;
    else if (cur == fwd_next(prev)) t = TR_FWD;
    else if (prev == fwd_next(cur)) t = TR_REV;
    else                            t = TR_ILLEGAL;
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_step_decoder_glitch_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// quad_glitch_filter: per-channel synchroniser plus consecutive-sample glitch
// filter with a direct-load (prime) path.                      Rev 1.0
// ---------------------------------------------------------------------------
module quad_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic prime,
  output logic filt
);

  localparam int CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   raw_s;

  assign raw_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // The filtered level only follows raw_s after FILT_CYCLES differing samples in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (prime) begin
      filt <= raw_s;
      cnt  <= '0;
    end else if (raw_s != filt) begin
      if (cnt == CNT_LAST) begin
        filt <= raw_s;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/quad_step_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// quad_step_decoder: quadrature A/B to step/dir front end for the up/down
// counter, with priming FSM and illegal-transition tracking.   Rev 1.0
// ---------------------------------------------------------------------------
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             err_clr,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             primed
);

  localparam int PRIME_LEN = SYNC_STAGES + FILT_CYCLES;
  localparam int PC_W      = $clog2(PRIME_LEN);
  localparam logic [PC_W-1:0] PRIME_LAST = PC_W'(PRIME_LEN - 1);

  state_t           state;
  logic [PC_W-1:0]  prime_cnt;
  logic [1:0]       prev;
  logic [1:0]       cur;
  logic             filt_a;
  logic             filt_b;
  logic             prime;
  trans_t           tr;
  logic             err_base;
  logic [ERR_W-1:0] cnt_base;

  assign prime = (state == PRIME);
  assign cur   = {filt_a, filt_b};
  assign tr    = (state == RUN) ? classify(prev, cur) : TR_NONE;

  quad_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES)
  ) u_filt_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (a_in),
    .prime (prime),
    .filt  (filt_a)
  );

  quad_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES)
  ) u_filt_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (b_in),
    .prime (prime),
    .filt  (filt_b)
  );

  // A clear that lands on an illegal transition still records that transition.
  always_comb begin
    err_base = err;
    cnt_base = err_cnt;
    if (err_clr) begin
      err_base = 1'b0;
      cnt_base = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PRIME;
      prime_cnt <= '0;
      prev      <= PH_00;
      step      <= 1'b0;
      dir       <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      primed    <= 1'b0;
    end else begin
      prev    <= cur;
      step    <= 1'b0;
      err     <= err_base;
      err_cnt <= cnt_base;
      case (state)
        PRIME: begin
          if (prime_cnt == PRIME_LAST) begin
            state  <= RUN;
            primed <= 1'b1;
          end else begin
            prime_cnt <= prime_cnt + 1'b1;
          end
        end
        RUN: begin
          case (tr)
            TR_FWD: begin
              step <= en;
              dir  <= 1'b0;
            end
            TR_REV: begin
              step <= en;
              dir  <= 1'b1;
            end
            TR_ILLEGAL: begin
              err     <= 1'b1;
              err_cnt <= (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
            end
            default: ;
          endcase
        end
        default: state <= PRIME;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_quad_step_decoder: directed plus random A/B stimulus against a
// phase-arithmetic reference model.                            Rev 1.0
// ---------------------------------------------------------------------------
module tb_quad_step_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_CYCLES = 4;
  localparam int ERR_W       = 4;
  localparam int LAT         = SYNC_STAGES + FILT_CYCLES + 1;
  localparam int NEV         = 4096;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b1;
  logic             a_in = 1'b0;
  logic             b_in = 1'b0;
  logic             err_clr = 1'b0;
  logic             step;
  logic             dir;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic             primed;

  quad_step_decoder #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES),
    .ERR_W       (ERR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .a_in    (a_in),
    .b_in    (b_in),
    .err_clr (err_clr),
    .step    (step),
    .dir     (dir),
    .err     (err),
    .err_cnt (err_cnt),
    .primed  (primed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int ev [NEV];              // per-edge expected transition: 0 none, 1 fwd, 2 rev, 3 illegal
  int gidx [4] = '{0, 1, 3, 2}; // position of phase value {A,B} around the quadrature cycle
  logic [1:0] ph = 2'b00;

  bit m_step = 0, m_dir = 0, m_err = 0, m_primed = 0;
  int m_cnt = 0;
  int prime_left = 0;
  int pulses = 0;
  int acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit r, e, c;
    int k;
    r = rst; e = en; c = err_clr;
    @(posedge clk);
    n++;
    #1;
    if (r) begin
      m_step = 0; m_dir = 0; m_err = 0; m_cnt = 0; m_primed = 0;
      prime_left = SYNC_STAGES + FILT_CYCLES;
    end else begin
      m_step = 0;
      if (c) begin
        m_err = 0;
        m_cnt = 0;
      end
      if (prime_left > 0) begin
        prime_left--;
        m_primed = (prime_left == 0);
      end else begin
        k = (n < NEV) ? ev[n] : 0;
        if (k == 1 || k == 2) begin
          m_step = e;
          m_dir  = (k == 2);
        end else if (k == 3) begin
          m_err = 1;
          if (m_cnt < (1 << ERR_W) - 1) m_cnt++;
        end
      end
    end
    if (step === 1'b1) begin
      pulses++;
      acc = dir ? acc - 1 : acc + 1;
    end
    chk("step", step, m_step);
    chk("dir", dir, m_dir);
    chk("err", err, m_err);
    chk("err_cnt", err_cnt, m_cnt);
    chk("primed", primed, m_primed);
  endtask

  // Apply a new {A,B} phase and hold it; the expected decode lands LAT edges later.
  task automatic set_ab(input logic [1:0] nph, input int hold);
    int d;
    d = (gidx[nph] - gidx[ph] + 4) % 4;
    if (d != 0 && n + LAT < NEV) ev[n + LAT] = (d == 1) ? 1 : (d == 3) ? 2 : 3;
    ph   = nph;
    a_in = nph[1];
    b_in = nph[0];
    repeat (hold) tick();
  endtask

  task automatic glitch(input bit on_a, input int len);
    if (on_a) a_in = ~a_in;
    else      b_in = ~b_in;
    repeat (len) tick();
    a_in = ph[1];
    b_in = ph[0];
    repeat (2) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("primed_after_prime", primed, 1);

    pulses = 0;
    set_ab(2'b01, 10); set_ab(2'b11, 10); set_ab(2'b10, 10); set_ab(2'b00, 10);
    chk("fwd_pulses", pulses, 4);

    pulses = 0; acc = 0;
    set_ab(2'b10, 10); set_ab(2'b11, 10); set_ab(2'b01, 10); set_ab(2'b00, 10);
    chk("rev_pulses", pulses, 4);
    chk("rev_count", acc & 15, 12);

    pulses = 0;
    glitch(1'b1, 2);
    repeat (6) tick();
    chk("glitch_pulses", pulses, 0);

    set_ab(2'b11, 10);
    chk("illegal_cnt", err_cnt, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    chk("clr_cnt", err_cnt, 0);
    for (int i = 0; i < 16; i++) set_ab((i % 2 == 0) ? 2'b00 : 2'b11, 8);
    chk("sat_cnt", err_cnt, 15);

    set_ab(2'b00, LAT - 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_coincide_cnt", err_cnt, 1);
    chk("clr_coincide_err", err, 1);
    repeat (4) tick();

    pulses = 0;
    en = 1'b0;
    set_ab(2'b01, 10); set_ab(2'b11, 10);
    en = 1'b1;
    repeat (4) tick();
    chk("en_off_pulses", pulses, 0);
    set_ab(2'b10, 10);
    chk("en_on_pulses", pulses, 1);

    set_ab(2'b11, 10);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_primed_low", primed, 0);
    tick();
    chk("rst_primed_high", primed, 1);
    pulses = 0;
    repeat (4) tick();
    chk("rst_no_step", pulses, 0);
    set_ab(2'b10, 10);
    chk("rst_next_pulses", pulses, 1);
    chk("rst_next_dir", dir, 0);

    for (int s = 0; s < 40; s++) begin
      en = ($urandom_range(0, 3) != 0);
      set_ab(2'($urandom_range(0, 3)), 8 + $urandom_range(0, 6));
      if ($urandom_range(0, 2) == 0) glitch($urandom_range(0, 1) == 1, $urandom_range(1, FILT_CYCLES - 1));
      if ($urandom_range(0, 4) == 0) begin
        err_clr = 1'b1; tick(); err_clr = 1'b0;
      end
    end
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
